// File: rtl/grid_editor.sv
// Cursor-driven pattern editor for the Game of Life grid: edits a pattern buffer while paused,
// emits one-cycle injection pulses while running, and captures the live board on pause.
module grid_editor #(
  parameter int unsigned ROWS         = 16,
  parameter int unsigned COLS         = 16,
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    gameState,
  input  logic                    key_up,
  input  logic                    key_down,
  input  logic                    key_left,
  input  logic                    key_right,
  input  logic                    key_place,
  input  logic                    key_clear,
  input  logic [ROWS*COLS-1:0]    grid_status,
  output logic [ROWS*COLS-1:0]    userInput,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    cursor_blink
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CLW  = $clog2(COLS);
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW   = $clog2(RMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_CYCLES);

  logic up_q, down_q, left_q, right_q, place_q, clear_q, gs_q;
  logic up_r, down_r, left_r, right_r, place_e, clear_e, capture;

  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic [IW-1:0]  idx;

  logic [CW-1:0] v_cnt_q, v_cnt_d, v_thr;
  logic [CW-1:0] h_cnt_q, h_cnt_d, h_thr;
  logic          v_rep_q, v_rep_d, h_rep_q, h_rep_d;
  logic          v_hold, h_hold, v_step, h_step;

  logic [N-1:0]  pattern_q, pattern_d;
  logic [N-1:0]  pulse_q, pulse_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    // First paused cycle after running: reload the board, ignore key edges.
    capture = gs_q & ~gameState;
    up_r    = key_up & ~up_q;
    down_r  = key_down & ~down_q;
    left_r  = key_left & ~left_q;
    right_r = key_right & ~right_q;
    place_e = key_place & ~place_q & ~capture;
    clear_e = key_clear & ~clear_q & ~capture;
    idx     = IW'(row_q) * IW'(COLS) + IW'(col_q);

    v_hold  = key_up ^ key_down;
    v_thr   = v_rep_q ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
    v_cnt_d = '0;
    v_rep_d = 1'b0;
    v_step  = 1'b0;
    if (v_hold) begin
      if (up_r | down_r) begin
        v_cnt_d = CW'(1);
        v_step  = ~capture;
      end else if (v_cnt_q == v_thr) begin
        v_cnt_d = CW'(1);
        v_rep_d = 1'b1;
        v_step  = 1'b1;
      end else begin
        v_cnt_d = v_cnt_q + CW'(1);
        v_rep_d = v_rep_q;
      end
    end

    h_hold  = key_left ^ key_right;
    h_thr   = h_rep_q ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
    h_cnt_d = '0;
    h_rep_d = 1'b0;
    h_step  = 1'b0;
    if (h_hold) begin
      if (left_r | right_r) begin
        h_cnt_d = CW'(1);
        h_step  = ~capture;
      end else if (h_cnt_q == h_thr) begin
        h_cnt_d = CW'(1);
        h_rep_d = 1'b1;
        h_step  = 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
        h_rep_d = h_rep_q;
      end
    end

    row_d = row_q;
    if (v_step) begin
      if (key_up) row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
      else        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end
    col_d = col_q;
    if (h_step) begin
      if (key_left) col_d = (col_q == '0) ? CLW'(COLS - 1) : col_q - CLW'(1);
      else          col_d = (col_q == CLW'(COLS - 1)) ? '0 : col_q + CLW'(1);
    end

    // Toggle/inject use the cursor position before this cycle's move.
    pattern_d = pattern_q;
    pulse_d   = '0;
    if (capture) begin
      pattern_d = grid_status;
    end else if (!gameState) begin
      if (clear_e)      pattern_d = '0;
      else if (place_e) pattern_d[idx] = ~pattern_q[idx];
    end else if (place_e) begin
      pulse_d[idx] = 1'b1;
    end

    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      place_q     <= 1'b0;
      clear_q     <= 1'b0;
      gs_q        <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      v_cnt_q     <= '0;
      h_cnt_q     <= '0;
      v_rep_q     <= 1'b0;
      h_rep_q     <= 1'b0;
      pattern_q   <= '0;
      pulse_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      up_q        <= key_up;
      down_q      <= key_down;
      left_q      <= key_left;
      right_q     <= key_right;
      place_q     <= key_place;
      clear_q     <= key_clear;
      gs_q        <= gameState;
      row_q       <= row_d;
      col_q       <= col_d;
      v_cnt_q     <= v_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_rep_q     <= v_rep_d;
      h_rep_q     <= h_rep_d;
      pattern_q   <= pattern_d;
      pulse_q     <= pulse_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign userInput    = gameState ? pulse_q : pattern_q;
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;
  assign cursor_blink = blink_q;

endmodule
